// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a byte FIFO and CPU-visible status registers
module uart_rx_fifo #(
    parameter int clk_freq_hz = 12_000_000,
    parameter int baud_rate   = 9600,
    parameter int DEPTH       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rxd,
    input  logic        i_sel,
    input  logic        i_rstrb,
    input  logic [3:0]  i_wmask,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_avail
);
    localparam int DIV = clk_freq_hz / baud_rate;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state;
    logic [2:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovr;
    logic          r_ferr;

    logic        w_rx;
    logic        w_fall;
    logic        w_stop_done;
    logic        w_push;
    logic        w_ferr;
    logic        w_rd;
    logic        w_wr;
    logic [1:0]  w_reg;
    logic        w_ne;
    logic        w_full;
    logic        w_pop;
    logic        w_acc;
    logic        w_clr;
    logic [31:0] w_status;
    logic        w_unused;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_sync[2] & ~r_sync[1];
    assign w_stop_done = (r_state == S_STOP) && (r_cnt == '0);
    assign w_push      = w_stop_done & w_rx;
    assign w_ferr      = w_stop_done & ~w_rx;
    assign w_rd        = i_sel & i_rstrb;
    assign w_wr        = i_sel & |i_wmask;
    assign w_reg       = i_addr[3:2];
    assign w_ne        = r_count != '0;
    assign w_full      = r_count == (AW+1)'(DEPTH);
    assign w_pop       = w_rd && (w_reg == 2'd0) && w_ne;
    // a push into a full FIFO is only accepted when the same edge frees a slot
    assign w_acc       = w_push & (~w_full | w_pop);
    assign w_clr       = w_wr && (w_reg == 2'd1);
    assign w_status    = {{(23-AW){1'b0}}, r_count, 4'b0, r_ferr, r_ovr, w_full, w_ne};
    assign o_avail     = w_ne;
    assign w_unused    = ^{i_addr[1:0], i_wdata[31:4], i_wdata[1:0]};

    // two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= 3'b111;
        else       r_sync <= {r_sync[1:0], i_rxd};
    end

    // receive FSM: half-bit start check, then one sample per bit period
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_M1;
                    end
                end
                S_START: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else if (w_rx)   r_state <= S_IDLE;
                    else begin
                        r_state <= S_DATA;
                        r_cnt   <= FULL_M1;
                        r_bit   <= '0;
                    end
                end
                S_DATA: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_cnt   <= FULL_M1;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) r_state <= S_STOP;
                    end
                end
                default: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else             r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates visibility
    always_ff @(posedge i_clk) begin
        if (w_acc) r_mem[r_wp] <= r_shift;
    end

    // FIFO pointers, occupancy and sticky error flags (set wins over clear)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_acc) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_acc) - (AW+1)'(w_pop);
            r_ovr   <= (r_ovr & ~(w_clr & i_wdata[2])) | (w_push & ~w_acc);
            r_ferr  <= (r_ferr & ~(w_clr & i_wdata[3])) | w_ferr;
        end
    end

    // registered read data, held until the next read strobe
    always_ff @(posedge i_clk) begin
        if (i_rst)     o_rdata <= '0;
        else if (w_rd) o_rdata <= (w_reg == 2'd0) ? (w_ne ? {23'b0, 1'b1, r_mem[r_rp]} : 32'd0) :
                                  (w_reg == 2'd1) ? w_status : 32'd0;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for the UART receive FIFO
module tb_uart_rx_fifo;
    localparam int DIV   = 10;
    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        i_rst = 1;
    logic        i_rxd = 1;
    logic        i_sel = 0;
    logic        i_rstrb = 0;
    logic [3:0]  i_wmask = 0;
    logic [3:0]  i_addr = 0;
    logic [31:0] i_wdata = 0;
    logic [31:0] o_rdata;
    logic        o_avail;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    logic        m_ovr = 0;
    logic        m_ferr = 0;

    uart_rx_fifo #(.clk_freq_hz(1_000_000), .baud_rate(100_000), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_rxd(i_rxd), .i_sel(i_sel), .i_rstrb(i_rstrb),
        .i_wmask(i_wmask), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata), .o_avail(o_avail)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_status();
        int c = q.size();
        return {20'b0, 4'(c), 4'b0, m_ferr, m_ovr, c == DEPTH, c != 0};
    endfunction

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        i_sel = 1; i_rstrb = 1; i_addr = a;
        tick();
        i_sel = 0; i_rstrb = 0;
        d = o_rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        i_sel = 1; i_wmask = 4'hF; i_addr = a; i_wdata = d;
        tick();
        i_sel = 0; i_wmask = 0; i_wdata = 0;
        if (a[3:2] == 2'd1) begin
            if (d[2]) m_ovr = 0;
            if (d[3]) m_ferr = 0;
        end
    endtask

    task automatic chk_status(input string tag);
        logic [31:0] d;
        rd(4'h4, d);
        chk(tag, d, m_status());
    endtask

    task automatic chk_data(input string tag);
        logic [31:0] d, e;
        rd(4'h0, d);
        e = (q.size() != 0) ? q.pop_front() : 32'd0;
        chk(tag, d, e);
    endtask

    // drives one 10-bit frame; optionally strobes an RXDATA read at tick rd_at;
    // lat is the tick on which o_avail was first seen high (-1 if never)
    task automatic frame(input logic [7:0] b, input logic stop, input int rd_at, output int lat);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        lat = -1;
        for (int t = 0; t < 10 * DIV; t++) begin
            i_rxd = bits[t / DIV];
            i_sel = (t == rd_at); i_rstrb = (t == rd_at); i_addr = 0;
            tick();
            if (lat < 0 && o_avail) lat = t + 1;
        end
        i_rxd = 1; i_sel = 0; i_rstrb = 0;
        if (rd_at < 0) begin
            if (!stop)                 m_ferr = 1;
            else if (q.size() < DEPTH) q.push_back({24'h000001, b});
            else                       m_ovr = 1;
        end
    endtask

    initial begin
        int lat0, l;
        logic [31:0] e;
        repeat (3) tick();
        i_rst = 0;
        tick();
        chk("reset_rdata", o_rdata, 0);
        chk("reset_avail", 32'(o_avail), 0);
        chk_status("reset_status");

        frame(8'hA5, 1, -1, lat0);
        chk("latency_window", 32'(lat0 >= 97 && lat0 <= 99), 1);
        chk_status("single_status");
        chk_data("single_data");
        chk_status("single_status_empty");
        chk_data("single_data_empty");

        for (int i = 1; i <= 9; i++) frame(8'(i), 1, -1, l);
        repeat (5) tick();
        chk_status("overrun_status");
        for (int i = 0; i < 9; i++) chk_data("overrun_data");
        wr(4'h4, 32'h4);
        chk_status("overrun_cleared");

        frame(8'h55, 0, -1, l);
        repeat (5) tick();
        chk_status("frame_err_status");
        wr(4'h4, 32'h8);
        chk_status("frame_err_cleared");

        i_rxd = 0;
        repeat (3) tick();
        i_rxd = 1;
        repeat (120) tick();
        chk_status("glitch_status");
        i_rxd = 0;
        repeat (200) tick();
        i_rxd = 1;
        repeat (20) tick();
        m_ferr = 1;
        chk_data("break_data");
        chk_status("break_status");
        wr(4'h4, 32'h8);

        i_rxd = 0;
        repeat (5 * DIV) tick();
        i_rxd = 1;
        repeat (3) tick();
        i_rst = 1;
        tick();
        i_rst = 0;
        q.delete(); m_ovr = 0; m_ferr = 0;
        chk("midframe_rst_rdata", o_rdata, 0);
        repeat (8 * DIV) tick();
        chk_status("midframe_rst_status");
        frame(8'h3C, 1, -1, l);
        repeat (5) tick();
        chk_status("after_rst_status");
        chk_data("after_rst_data");

        for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1, -1, l);
        repeat (5) tick();
        chk_status("full_status");
        e = q.pop_front();
        q.push_back(32'h118);
        frame(8'h18, 1, lat0 - 1, l);
        chk("simul_pop_data", o_rdata, e);
        repeat (5) tick();
        chk_status("simul_status");
        for (int i = 0; i < 8; i++) chk_data("wrap_order");
        chk_status("final_status");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
